// File: rtl/onehot_digit_sequencer.sv
// onehot_digit_sequencer: two raw pushbuttons plus an auto-advance mode
// drive a wrapping 3-bit digit, its registered one-hot code and a wrap pulse.
// Button path: 2-flop synchroniser -> debouncer -> rising-edge press detect.
//
// Handshake: there is none. Every input is sampled on each rising clk edge,
// and every output is a registered level that holds until the next edge.
module onehot_digit_sequencer #(
  parameter int unsigned DEBOUNCE_CYCLES = 4,
  parameter int unsigned AUTO_DIV        = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       btn_up_raw,
  input  logic       btn_dn_raw,
  input  logic       auto_en,
  input  logic       clr,
  output logic [2:0] digit,
  output logic [7:0] onehot,
  output logic       wrap
);

  localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES) + 1;
  localparam int unsigned PW = $clog2(AUTO_DIV);
  localparam logic [CW-1:0] DB_LAST  = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [PW-1:0] PRE_LAST = PW'(AUTO_DIV - 1);

  // Index 0 is the up button, index 1 is the down button.
  logic [1:0]    s1_q, s1_d;
  logic [1:0]    s2_q, s2_d;
  logic [1:0]    stable_q, stable_d;
  logic [1:0]    prev_q, prev_d;
  logic [CW-1:0] cnt_q [2];
  logic [CW-1:0] cnt_d [2];
  logic [PW-1:0] pre_q, pre_d;
  logic [2:0]    digit_q, digit_d;
  logic [7:0]    onehot_q, onehot_d;
  logic          wrap_q, wrap_d;

  logic [1:0]    press;
  logic          adv;

  // Two-flop synchronisers; only the second stage is used downstream.
  always_comb begin
    s1_d = {btn_dn_raw, btn_up_raw};
    s2_d = s1_q;
  end

  // Debounce: the stable level flips after DEBOUNCE_CYCLES consecutive
  // synchronised samples that disagree with it; any agreement restarts the count.
  always_comb begin
    stable_d = stable_q;
    for (int b = 0; b < 2; b++) begin
      cnt_d[b] = '0;
      if (s2_q[b] == stable_q[b]) begin
        cnt_d[b] = '0;
      end else if (cnt_q[b] == DB_LAST) begin
        stable_d[b] = s2_q[b];
        cnt_d[b]    = '0;
      end else begin
        cnt_d[b] = cnt_q[b] + CW'(1);
      end
    end
  end

  // Press detect: one-cycle pulse on a rising stable level; releases are ignored.
  always_comb begin
    prev_d = stable_q;
    press  = stable_q & ~prev_q;
  end

  // Auto-advance prescaler: held at zero when disabled or cleared, so
  // re-enabling always starts a full period.
  always_comb begin
    adv = auto_en && (pre_q == PRE_LAST);
    if (clr || !auto_en) begin
      pre_d = '0;
    end else if (pre_q == PRE_LAST) begin
      pre_d = '0;
    end else begin
      pre_d = pre_q + PW'(1);
    end
  end

  // Digit update in priority order: clear, simultaneous presses, up, down, auto.
  always_comb begin
    digit_d = digit_q;
    wrap_d  = 1'b0;
    if (clr) begin
      digit_d = 3'd0;
    end else if (press[0] && press[1]) begin
      digit_d = digit_q;
    end else if (press[0] || (!press[1] && adv)) begin
      digit_d = digit_q + 3'd1;
      wrap_d  = (digit_q == 3'd7);
    end else if (press[1]) begin
      digit_d = digit_q - 3'd1;
      wrap_d  = (digit_q == 3'd0);
    end
    onehot_d = 8'h01 << digit_d;
  end

  // Button-path registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q     <= '0;
      s2_q     <= '0;
      stable_q <= '0;
      prev_q   <= '0;
      for (int b = 0; b < 2; b++) begin
        cnt_q[b] <= '0;
      end
    end else begin
      s1_q     <= s1_d;
      s2_q     <= s2_d;
      stable_q <= stable_d;
      prev_q   <= prev_d;
      for (int b = 0; b < 2; b++) begin
        cnt_q[b] <= cnt_d[b];
      end
    end
  end

  // Prescaler and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pre_q    <= '0;
      digit_q  <= 3'd0;
      onehot_q <= 8'h01;
      wrap_q   <= 1'b0;
    end else begin
      pre_q    <= pre_d;
      digit_q  <= digit_d;
      onehot_q <= onehot_d;
      wrap_q   <= wrap_d;
    end
  end

  assign digit  = digit_q;
  assign onehot = onehot_q;
  assign wrap   = wrap_q;

endmodule

// File: tb/tb_onehot_digit_sequencer.sv
// Testbench for onehot_digit_sequencer: directed scenarios with literal
// expectations, then randomized buttons/auto/clr/reset, all compared every
// cycle against a history-based behavioural model.
module tb_onehot_digit_sequencer;

  localparam int D  = 4;
  localparam int AD = 8;

  // ---------------- clock / reset ----------------
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       btn_up_raw = 1'b0;
  logic       btn_dn_raw = 1'b0;
  logic       auto_en = 1'b0;
  logic       clr = 1'b0;
  logic [2:0] digit;
  logic [7:0] onehot;
  logic       wrap;

  always #5 clk = ~clk;

  onehot_digit_sequencer #(.DEBOUNCE_CYCLES(D), .AUTO_DIV(AD)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .btn_up_raw (btn_up_raw),
    .btn_dn_raw (btn_dn_raw),
    .auto_en    (auto_en),
    .clr        (clr),
    .digit      (digit),
    .onehot     (onehot),
    .wrap       (wrap)
  );

  // ---------------- scoreboard counters ----------------
  int vectors = 0;
  int miscompares = 0;
  int wcount;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Raw samples per edge and synchronised samples per edge since reset;
  // a stable level flips once the last D synchronised samples all disagree.
  bit raw_hist [2][$];
  bit syn_hist [2][$];
  bit m_stable [2];
  bit m_pend   [2];
  int m_run;
  int m_digit;
  bit m_wrap;

  task automatic model_reset();
    for (int b = 0; b < 2; b++) begin
      raw_hist[b].delete();
      syn_hist[b].delete();
      m_stable[b] = 1'b0;
      m_pend[b]   = 1'b0;
    end
    m_run   = 0;
    m_digit = 0;
    m_wrap  = 1'b0;
  endtask

  task automatic model_step(input bit up, input bit dn, input bit au, input bit cl);
    bit press_up, press_dn, adv, s2, flip;
    int n;
    press_up = m_pend[0];
    press_dn = m_pend[1];
    adv = au && ((m_run % AD) == AD - 1);
    m_wrap = 1'b0;
    if (cl) begin
      m_digit = 0;
    end else if (press_up && press_dn) begin
      m_digit = m_digit;
    end else if (press_up || (!press_dn && adv)) begin
      m_wrap  = (m_digit == 7);
      m_digit = (m_digit + 1) % 8;
    end else if (press_dn) begin
      m_wrap  = (m_digit == 0);
      m_digit = (m_digit + 7) % 8;
    end
    m_run = (cl || !au) ? 0 : m_run + 1;
    for (int b = 0; b < 2; b++) begin
      n  = raw_hist[b].size();
      s2 = (n >= 2) ? raw_hist[b][n-2] : 1'b0;
      raw_hist[b].push_back(b == 0 ? up : dn);
      if (raw_hist[b].size() > 4) void'(raw_hist[b].pop_front());
      syn_hist[b].push_back(s2);
      if (syn_hist[b].size() > D + 2) void'(syn_hist[b].pop_front());
      n = syn_hist[b].size();
      flip = (n >= D);
      for (int i = 0; i < D && i < n; i++) begin
        if (syn_hist[b][n-1-i] == m_stable[b]) flip = 1'b0;
      end
      m_pend[b] = flip && !m_stable[b];
      if (flip) m_stable[b] = !m_stable[b];
    end
  endtask

  // ---------------- per-cycle compare ----------------
  task automatic compare_model();
    logic [7:0] e;
    e = 8'h01;
    e = e << m_digit;
    chk("digit", {29'd0, digit}, m_digit);
    chk("onehot", {24'd0, onehot}, {24'd0, e});
    chk("wrap", {31'd0, wrap}, {31'd0, m_wrap});
  endtask

  // ---------------- driver tasks ----------------
  // Inputs change after the falling edge; one active edge; outputs checked
  // on the following falling edge.
  task automatic tick();
    @(posedge clk);
    model_step(btn_up_raw, btn_dn_raw, auto_en, clr);
    @(negedge clk);
    compare_model();
    if (wrap === 1'b1) wcount++;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  // Asynchronous reset asserted between edges; outputs must clear at once.
  task automatic do_reset();
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    chk("async_rst_digit", {29'd0, digit}, 32'd0);
    chk("async_rst_onehot", {24'd0, onehot}, 32'h01);
    chk("async_rst_wrap", {31'd0, wrap}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // ---------------- main sequence ----------------
  initial begin
    model_reset();
    @(negedge clk);
    chk("reset_digit", {29'd0, digit}, 32'd0);
    chk("reset_onehot", {24'd0, onehot}, 32'h01);
    chk("reset_wrap", {31'd0, wrap}, 32'd0);
    rst_n = 1'b1;

    // Debounced up press: action at edge D+2 = 6, exactly once while held.
    btn_up_raw = 1'b1;
    ticks(6);
    chk("up_before_edge6", {29'd0, digit}, 32'd0);
    tick();
    chk("up_at_edge6", {29'd0, digit}, 32'd1);
    chk("up_onehot_edge6", {24'd0, onehot}, 32'h02);
    ticks(50);
    chk("up_held_once", {29'd0, digit}, 32'd1);
    btn_up_raw = 1'b0;
    ticks(10);

    // Glitch of 3 raw cycles is rejected.
    wcount = 0;
    btn_up_raw = 1'b1;
    ticks(3);
    btn_up_raw = 1'b0;
    ticks(12);
    chk("glitch_digit", {29'd0, digit}, 32'd1);
    chk("glitch_wraps", wcount, 32'd0);

    // Auto-advance from reset release: increments at edges 7, 15, ...
    do_reset();
    auto_en = 1'b1;
    wcount = 0;
    ticks(7);
    chk("auto_edge6", {29'd0, digit}, 32'd0);
    tick();
    chk("auto_edge7", {29'd0, digit}, 32'd1);
    ticks(55);
    chk("auto_edge62_nowrap", wcount, 32'd0);
    tick();
    chk("auto_edge63_wrap", {31'd0, wrap}, 32'd1);
    chk("auto_64_digit", {29'd0, digit}, 32'd0);
    chk("auto_64_wraps", wcount, 32'd1);
    ticks(56);
    chk("auto_reach7", {29'd0, digit}, 32'd7);
    auto_en = 1'b0;

    // Up from 7 wraps to 0.
    btn_up_raw = 1'b1;
    ticks(7);
    chk("wrap_up_digit", {29'd0, digit}, 32'd0);
    chk("wrap_up_onehot", {24'd0, onehot}, 32'h01);
    chk("wrap_up_pulse", {31'd0, wrap}, 32'd1);
    tick();
    chk("wrap_up_pulse_end", {31'd0, wrap}, 32'd0);
    btn_up_raw = 1'b0;
    ticks(10);

    // Down from 0 wraps to 7.
    btn_dn_raw = 1'b1;
    ticks(7);
    chk("wrap_dn_digit", {29'd0, digit}, 32'd7);
    chk("wrap_dn_onehot", {24'd0, onehot}, 32'h80);
    chk("wrap_dn_pulse", {31'd0, wrap}, 32'd1);
    btn_dn_raw = 1'b0;
    ticks(10);

    // Simultaneous presses cancel.
    btn_up_raw = 1'b1;
    btn_dn_raw = 1'b1;
    ticks(7);
    chk("both_digit", {29'd0, digit}, 32'd7);
    chk("both_wrap", {31'd0, wrap}, 32'd0);
    btn_up_raw = 1'b0;
    btn_dn_raw = 1'b0;
    ticks(10);

    // clr wins over an up press in the same cycle.
    btn_up_raw = 1'b1;
    ticks(6);
    clr = 1'b1;
    tick();
    chk("clr_up_digit", {29'd0, digit}, 32'd0);
    chk("clr_up_wrap", {31'd0, wrap}, 32'd0);
    clr = 1'b0;
    ticks(3);
    chk("clr_press_gone", {29'd0, digit}, 32'd0);
    btn_up_raw = 1'b0;
    ticks(10);

    // Randomized phase.
    for (int c = 0; c < 2000; c++) begin
      if ($urandom_range(0, 5) == 0) btn_up_raw = ~btn_up_raw;
      if ($urandom_range(0, 5) == 0) btn_dn_raw = ~btn_dn_raw;
      if ($urandom_range(0, 39) == 0) auto_en = ~auto_en;
      clr = ($urandom_range(0, 39) == 0);
      if ($urandom_range(0, 299) == 0) do_reset();
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
